iter_divider: RTL and testbench
===============================

// Module: iter_divider
// PURPOSE
//  Multi-cycle integer divider for MIPS DIV/DIVU; the inverse of the ALU's single-cycle multiply.
//  Accepts a dividend/divisor pair and computes one quotient bit per clock (restoring algorithm).
//  Returns quotient (Lo) and remainder (Hi) to the HI/LO registers with a start/busy/done handshake.
//  Sits beside the ALU in the datapath; the control unit stalls on busy.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4); iteration count equals WIDTH
// PORTS
//  clk          in   1      single clock; all state updates on rising edge
//  rst_n        in   1      synchronous, active-low reset
//  start        in   1      request; sampled only in IDLE or DONE
//  sign         in   1      1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
//  dividend     in   WIDTH  numerator; sampled with start
//  divisor      in   WIDTH  denominator; sampled with start
//  busy         out  1      high in RUN and FIX
//  done         out  1      one-cycle pulse: results valid
//  quotient     out  WIDTH  Lo result; registered, held until next accepted start
//  remainder    out  WIDTH  Hi result; registered, held until next accepted start
//  div_by_zero  out  1      set with done when divisor==0; held with results
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0.
//   Reset mid-operation aborts immediately; no done pulse for the aborted operation.
//  FSM: IDLE -> (start) RUN -> (count==WIDTH-1) FIX -> DONE -> IDLE. DONE+start -> RUN directly.
//   start with divisor==0: IDLE/DONE -> DONE next edge, skipping RUN and FIX.
//   start in RUN or FIX is ignored (no queueing).
//  Accept: on start, latch sign; when sign=1, latch |dividend| and |divisor| and the signs of
//   the quotient (dividend[MSB]^divisor[MSB]) and remainder (dividend[MSB]); clear counter.
//  RUN: each cycle shift the {rem,quo} pair left 1 bit; trial = rem - divisor in WIDTH+1 bits.
//   If trial >= 0, rem = trial and quo LSB = 1; otherwise keep rem and quo LSB = 0.
//   Exactly WIDTH RUN cycles.
//  FIX: when sign=1, negate quo and/or rem per the latched signs (two's complement, WIDTH bits).
//   Quotient truncates toward zero; remainder takes the dividend's sign.
//   Results are written to the quotient/remainder outputs at the end of FIX.
//  DONE: done=1 for exactly this cycle; busy=0. Outputs are stable from done until the next accept.
//  Latency: start high in cycle 0 -> done high in cycle WIDTH+2 (34 for default).
//   With divisor==0, done is high in cycle 1.
//  Divide by zero: quotient = all ones, remainder = dividend (raw), div_by_zero=1. No trap.
//  Signed overflow: -2^(WIDTH-1) / -1 -> quotient=0x80000000, remainder=0, div_by_zero=0. No flag.
//   The |x| of the most negative value is taken as an unsigned WIDTH-bit value (0x80000000).
//  div_by_zero is cleared on the next accepted start.
//  Back-to-back: start held high through DONE re-accepts on the DONE edge.
//   Results of the first operation remain valid through that DONE cycle only.
// TESTING
//  DIVU 100/7 (sign=0) -> done at cycle 34; quotient=14, remainder=2; busy high cycles 1..33.
//  DIV -7/2 (0xFFFFFFF9, 2, sign=1) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
//  DIV 0x80000000/0xFFFFFFFF, sign=1 -> quotient=0x80000000, remainder=0, div_by_zero=0.
//  DIVU 5/0 -> done at cycle 1; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
//  start pulsed again at cycle 10 of a 100/7 run -> ignored; single done at cycle 34, results 14/2.
//  rst_n=0 at cycle 15 of a run -> next cycle busy=0, outputs 0; no done; new start works normally.

Source files
------------

// File: rtl/iter_divider_if.sv
// Handshake/data bundle between the control unit and the iterative divider.
//   start, sign, dividend, divisor : request side, driven by the master
//   busy, done, quotient, remainder, div_by_zero : response side, driven by the divider
interface iter_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, sign, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, sign, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one quotient bit per clock.
// Quotient goes to LO and remainder to HI; the control unit stalls while busy.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset (aborts any operation in flight)
//   bus   : iter_divider_if slave modport (start/sign/dividend/divisor in,
//           busy/done/quotient/remainder/div_by_zero out)
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  iter_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] rem, quo, dvsr;
  logic             neg_q, neg_r;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             dbz_q;

  logic             accept, zero_div, fits;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;

  // Magnitude of a two's-complement value; the most negative value maps to
  // itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign accept   = bus.start && (state_q == IDLE || state_q == DONE);
  assign zero_div = (bus.divisor == '0);

  // Partial remainder never exceeds the divisor, so after the shift the
  // difference always fits back into WIDTH bits when the trial succeeds.
  assign shifted = {rem, quo[WIDTH-1]};
  assign fits    = shifted >= {1'b0, dvsr};
  assign trial   = shifted[WIDTH-1:0] - dvsr;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = zero_div ? DONE : RUN;
      RUN:  if (count == LAST) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: begin
        if (bus.start) state_d = zero_div ? DONE : RUN;
        else           state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Working registers: only meaningful after an accept, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem   <= '0;
      quo   <= bus.sign ? abs_val(bus.dividend) : bus.dividend;
      dvsr  <= bus.sign ? abs_val(bus.divisor)  : bus.divisor;
      neg_q <= bus.sign && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      neg_r <= bus.sign && bus.dividend[WIDTH-1];
      count <= '0;
    end else if (state_q == RUN) begin
      rem   <= fits ? trial : shifted[WIDTH-1:0];
      quo   <= {quo[WIDTH-2:0], fits};
      count <= count + CW'(1);
    end
  end

  // Architectural results: held until the next operation overwrites them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      dbz_q <= zero_div;
      if (zero_div) begin
        quotient_q  <= '1;
        remainder_q <= bus.dividend;
      end
    end else if (state_q == FIX) begin
      quotient_q  <= cond_neg(quo, neg_q);
      remainder_q <= cond_neg(rem, neg_r);
    end
  end

  assign bus.busy        = (state_q == RUN) || (state_q == FIX);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_divider.sv
module tb_iter_divider;

  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  iter_divider_if #(.WIDTH(32)) bus ();

  iter_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: MIPS DIV/DIVU semantics via plain integer arithmetic.
  function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    int sa, sb;
    z = (b == 0);
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end
  endfunction

  // Called at a negedge: request is sampled at the next rising edge (cycle 0).
  task automatic drive_start(input bit s, input logic [31:0] a, input logic [31:0] b);
    bus.start    = 1'b1;
    bus.sign     = s;
    bus.dividend = a;
    bus.divisor  = b;
  endtask

  // Entered in cycle 0 with the request already driven. Follows the operation
  // to its done pulse and checks latency, busy and results. When chain is set,
  // the next request is driven during the done cycle (back-to-back accept).
  task automatic run_check(input string tag, input bit s, input logic [31:0] a,
                           input logic [31:0] b, input int ign_cyc, input bit chain,
                           input bit ns, input logic [31:0] na, input logic [31:0] nb);
    logic [31:0] eq, er;
    logic        ez;
    int          cyc, elat;
    bit          busy_ok;
    model(s, a, b, eq, er, ez);
    elat = (b == 0) ? 1 : 34;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    cyc = 1;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == ign_cyc) drive_start(~s, $urandom, 32'd3);
      else bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, elat);
    check({tag, "_busy_run"}, {31'b0, busy_ok}, 32'd1);
    check({tag, "_busy_done"}, {31'b0, bus.busy}, 32'd0);
    check({tag, "_quotient"}, bus.quotient, eq);
    check({tag, "_remainder"}, bus.remainder, er);
    check({tag, "_dbz"}, {31'b0, bus.div_by_zero}, {31'b0, ez});
    if (chain) begin
      drive_start(ns, na, nb);
    end else begin
      bus.start = 1'b0;
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
      check({tag, "_hold_q"}, bus.quotient, eq);
    end
  endtask

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  op_t ops[24];

  initial begin
    int  cyc;
    bit  pending;
    bit  chain;
    bus.start    = 1'b0;
    bus.sign     = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_q", bus.quotient, 32'd0);
    check("rst_r", bus.remainder, 32'd0);
    check("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    drive_start(1'b0, 32'd100, 32'd7);
    run_check("divu_100_7", 1'b0, 32'd100, 32'd7, -1, 1'b0, 1'b0, 0, 0);
    drive_start(1'b1, 32'hFFFF_FFF9, 32'd2);
    run_check("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, 1'b0, 0, 0);
    drive_start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, 1'b0, 0, 0);
    drive_start(1'b0, 32'd5, 32'd0);
    run_check("divu_by0", 1'b0, 32'd5, 32'd0, -1, 1'b0, 1'b0, 0, 0);
    drive_start(1'b0, 32'd100, 32'd7);
    run_check("ign_start", 1'b0, 32'd100, 32'd7, 10, 1'b0, 1'b0, 0, 0);
    drive_start(1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
    run_check("div_max_min", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, -1, 1'b0, 1'b0, 0, 0);

    // Back-to-back: start held through DONE, including into a divide-by-zero
    drive_start(1'b0, 32'hFFFF_FFFF, 32'd10);
    run_check("b2b_a", 1'b0, 32'hFFFF_FFFF, 32'd10, -1, 1'b1, 1'b1, 32'hFFFF_FF00, 32'd0);
    run_check("b2b_b", 1'b1, 32'hFFFF_FF00, 32'd0, -1, 1'b1, 1'b1, 32'd9, 32'hFFFF_FFFD);
    run_check("b2b_c", 1'b1, 32'd9, 32'hFFFF_FFFD, -1, 1'b0, 1'b0, 0, 0);

    // Reset mid-operation (outputs currently hold nonzero results)
    drive_start(1'b0, 32'd5, 32'd0);
    run_check("pre_rst", 1'b0, 32'd5, 32'd0, -1, 1'b0, 1'b0, 0, 0);
    drive_start(1'b0, 32'd100, 32'd7);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i < 15; i++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    check("abort_q", bus.quotient, 32'd0);
    check("abort_r", bus.remainder, 32'd0);
    check("abort_dbz", {31'b0, bus.div_by_zero}, 32'd0);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) cyc++;
    end
    check("abort_no_done", cyc, 0);
    drive_start(1'b0, 32'd100, 32'd7);
    run_check("post_rst", 1'b0, 32'd100, 32'd7, -1, 1'b0, 1'b0, 0, 0);

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      ops[i].s = 1'($urandom);
      ops[i].a = $urandom;
      case ($urandom % 4)
        0:       ops[i].b = $urandom;
        1:       ops[i].b = $urandom % 16;
        2:       ops[i].b = -($urandom % 100);
        default: ops[i].b = $urandom >> ($urandom % 32);
      endcase
    end
    pending = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (!pending) drive_start(ops[i].s, ops[i].a, ops[i].b);
      chain = (i % 3 == 0) && (i < 23);
      if (chain)
        run_check($sformatf("rnd%0d", i), ops[i].s, ops[i].a, ops[i].b, -1, 1'b1,
                  ops[i+1].s, ops[i+1].a, ops[i+1].b);
      else
        run_check($sformatf("rnd%0d", i), ops[i].s, ops[i].a, ops[i].b, -1, 1'b0,
                  1'b0, 0, 0);
      pending = chain;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
